// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: synchronise and debounce slide switches, capture a data byte on the strobe switch
module sw_input_conditioner #(
    parameter int NSW       = 9,
    parameter int DB_CYCLES = 16,
    parameter int CW        = $clog2(DB_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NSW-1:0] sw_raw,
    input  logic           ack,
    output logic [NSW-1:0] sw_db,
    output logic [NSW-2:0] data,
    output logic           valid
);
    typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    state_t         state;
    logic [NSW-1:0] s1, s2;
    logic [CW-1:0]  cnt [NSW];
    logic           prev, rise, fall;
    assign rise = sw_db[NSW-1] & ~prev;
    assign fall = ~sw_db[NSW-1] & prev;
    // two-flop synchroniser on every raw switch pin
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    // per-bit debounce: accept a new level after DB_CYCLES consecutive mismatches
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sw_db <= '0;
            for (int i = 0; i < NSW; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NSW; i++)
                if (s2[i] == sw_db[i]) cnt[i] <= '0;
                else if (cnt[i] == LAST) begin
                    sw_db[i] <= s2[i];
                    cnt[i]   <= '0;
                end else cnt[i] <= cnt[i] + 1'b1;
        end
    // strobe history for one-cycle rise/fall events
    always_ff @(posedge clk or negedge reset)
        if (!reset) prev <= 1'b0;
        else prev <= sw_db[NSW-1];
    // capture/handshake FSM; valid is registered alongside the state
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (rise) begin
                        data  <= sw_db[NSW-2:0];
                        state <= VALID;
                        valid <= 1'b1;
                    end
                VALID:
                    if (fall) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end else if (ack) begin
                        state <= RELEASE;
                        valid <= 1'b0;
                    end
                RELEASE:
                    if (fall) state <= IDLE;
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_sw_input_conditioner.sv
// tb_sw_input_conditioner: directed scoreboard bench for the switch conditioner
module tb_sw_input_conditioner;
    localparam int NSW = 9;
    localparam int DB  = 4;
    logic           clk, reset, ack;
    logic [NSW-1:0] sw_raw, sw_db;
    logic [NSW-2:0] data;
    logic           valid;
    int             checks, passes, cap_cnt, c0, n;
    logic [7:0]     exp_q [$];
    logic [7:0]     mon_e;
    logic           vq;
    logic [NSW-1:0] acc_db;
    logic [NSW-2:0] acc_data;
    logic           acc_v;

    sw_input_conditioner #(.NSW(NSW), .DB_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .ack(ack),
        .sw_db(sw_db), .data(data), .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // monitor: every fresh valid assertion pops the next expected byte
    initial vq = 1'b0;
    always @(negedge clk) begin
        if (valid && !vq) begin
            cap_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_capture: got data %0h, expected no capture", data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("capture_data", 32'(data), 32'(mon_e));
            end
        end
        vq = valid;
    end

    task automatic clr();
        acc_db = '0;
        acc_data = '0;
        acc_v = 1'b0;
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            acc_db |= sw_db;
            acc_data |= data;
            acc_v |= valid;
        end
    endtask

    // counts rising edges, the first sampling edge included, until the signal reaches lvl
    task automatic edges_until(input bit use_valid, input logic lvl, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (((use_valid ? valid : sw_db[NSW-1]) != lvl) && cnt < 40);
    endtask

    task automatic wait_v(input string name);
        int k;
        k = 0;
        while (!valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(valid), 32'd1);
    endtask

    initial begin
        checks = 0; passes = 0; cap_cnt = 0;
        reset = 1'b0; ack = 1'b0; sw_raw = 9'h1FF;
        // 1: reset hold, then quiet release
        step(3);
        chk("t1_swdb_rst", 32'(sw_db), 32'd0);
        chk("t1_data_rst", 32'(data), 32'd0);
        chk("t1_valid_rst", 32'(valid), 32'd0);
        sw_raw = 9'h000;
        reset = 1'b1;
        clr();
        step(20);
        chk("t1_quiet", 32'({acc_v, acc_data, acc_db}), 32'd0);
        // 2: capture and handshake
        sw_raw = 9'h0A5;
        step(10);
        exp_q.push_back(8'hA5);
        sw_raw = 9'h1A5;
        edges_until(1'b0, 1'b1, n);
        chk("t2_strobe_latency", 32'(n), 32'd6);
        @(negedge clk);
        chk("t2_valid_rise_cycle", 32'(valid), 32'd0);
        @(negedge clk);
        chk("t2_valid", 32'(valid), 32'd1);
        chk("t2_swdb", 32'(sw_db), 32'h1A5);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("t2_ack_clear", 32'(valid), 32'd0);
        clr();
        sw_raw = 9'h0A5;
        step(10);
        chk("t2_valid_quiet", 32'(acc_v), 32'd0);
        chk("t2_data_hold", 32'(data), 32'hA5);
        // 3: bounce rejection, then a single clean capture
        sw_raw = 9'h03C;
        step(10);
        clr();
        repeat (2) begin
            sw_raw = 9'h13C;
            step(3);
            sw_raw = 9'h03C;
            step(3);
        end
        step(6);
        chk("t3_strobe_stable", 32'(acc_db[8]), 32'd0);
        chk("t3_valid_quiet", 32'(acc_v), 32'd0);
        c0 = cap_cnt;
        exp_q.push_back(8'h3C);
        sw_raw = 9'h13C;
        step(20);
        chk("t3_one_capture", 32'(cap_cnt - c0), 32'd1);
        chk("t3_valid", 32'(valid), 32'd1);
        // 4: abandon by releasing strobe, then re-press
        sw_raw = 9'h03C;
        edges_until(1'b1, 1'b0, n);
        chk("t4_abandon_latency", 32'(n), 32'd7);
        chk("t4_data_hold", 32'(data), 32'h3C);
        @(negedge clk);
        sw_raw = 9'h081;
        step(10);
        exp_q.push_back(8'h81);
        sw_raw = 9'h181;
        wait_v("t4_recapture_valid");
        // 5: data changes under strobe, ack coincident with fall, immediate re-press
        sw_raw = 9'h1FF;
        step(10);
        chk("t5_swdb_tracks", 32'(sw_db), 32'h1FF);
        chk("t5_data_frozen", 32'(data), 32'h81);
        sw_raw = 9'h0FF;
        edges_until(1'b0, 1'b0, n);
        chk("t5_fall_latency", 32'(n), 32'd6);
        @(negedge clk);
        ack = 1'b1;
        chk("t5_valid_at_fall", 32'(valid), 32'd1);
        @(negedge clk);
        ack = 1'b0;
        chk("t5_valid_clear", 32'(valid), 32'd0);
        exp_q.push_back(8'hFF);
        sw_raw = 9'h1FF;
        wait_v("t5_recapture_valid");
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("t5_ack_clear", 32'(valid), 32'd0);
        // 6: asynchronous reset mid-handshake, release with strobe held
        sw_raw = 9'h05A;
        step(10);
        exp_q.push_back(8'h5A);
        sw_raw = 9'h15A;
        wait_v("t6_valid");
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid_async", 32'(valid), 32'd0);
        chk("t6_data_async", 32'(data), 32'd0);
        chk("t6_swdb_async", 32'(sw_db), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(8'h5A);
        edges_until(1'b0, 1'b1, n);
        chk("t6_strobe_latency", 32'(n), 32'd6);
        @(negedge clk);
        wait_v("t6_recapture_valid");
        step(5);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
